uart_rx_stream: RTL and testbench

Serial-to-byte-stream front end for the UART probe. Samples the asynchronous UART RX pin, deframes 8N1 characters, and buffers received bytes in a small FIFO. Buffered bytes are presented on a valid/ready byte interface that connects directly to the probe's rx_valid/rx_data/rx_ready command input. Framing errors and overruns are flagged as single-cycle pulses for status logic.

---
 rtl/uart_rx_pkg.sv | 6 +
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx_stream.sv | 152 +++++++++++++++
 tb/tb_uart_rx_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive stream front end.
package uart_rx_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO holding received UART characters.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver: synchronizes uart_rxd, deframes 8N1 characters, buffers them in a FWFT FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_stream
  import uart_rx_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 868,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       m_areset,
  input  logic       uart_rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun
);
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CYCLES_PER_BIT - 1);

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [1:0]           sync;
  logic                 rxd_s, push, ferr_n, full, empty, pop;
  logic                 bad;
`ifdef UART_RX_PARITY_EN
  logic                 bad_n;
`else
  assign bad = 1'b0;
`endif

  assign rxd_s    = sync[1];
  assign rx_valid = !empty;
  assign pop      = rx_valid && rx_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    push    = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_n   = bad;
`endif
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          cnt_n   = HALF_BIT;
        end
      end
      START: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (rxd_s) state_n = IDLE;
        else begin
          state_n = DATA;
          cnt_n   = FULL_BIT;
          idx_n   = '0;
`ifdef UART_RX_PARITY_EN
          bad_n   = 1'b0;
`endif
        end
      end
      DATA: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          shift_n = {rxd_s, shift[DATA_BITS-1:1]};
          cnt_n   = FULL_BIT;
          idx_n   = idx + 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          cnt_n   = FULL_BIT;
          state_n = STOP;
          bad_n   = ^shift ^ rxd_s;
          ferr_n  = ^shift ^ rxd_s;
        end
      end
`endif
      STOP: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (rxd_s) begin
          push    = !bad;
          state_n = IDLE;
        end else begin
          // A parity failure already reported this frame; stay silent on the stop bit.
          ferr_n  = !bad;
          state_n = BREAK;
        end
      end
      BREAK: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge m_areset) begin
    if (m_areset) begin
      sync        <= 2'b11;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad         <= 1'b0;
`endif
    end else begin
      sync        <= {sync[0], uart_rxd};
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      frame_error <= ferr_n;
      overrun     <= push && full && !pop;
`ifdef UART_RX_PARITY_EN
      bad         <= bad_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (m_areset),
    .push (push),
    .pop  (pop),
    .din  (shift),
    .dout (rx_data),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream: directed frames plus randomized traffic against a queue-based model.
module tb_uart_rx_stream;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS   = 10 + PAR;
  // Stop-bit sample edge, counted from the edge before the start bit is driven:
  // 2 synchronizer edges + 1 IDLE edge, half a bit to mid-start, then 8 (+parity) + 1 bit periods.
  localparam int STOP_AT = 3 + CPB / 2 + CPB * (9 + PAR);

  logic       clk, m_areset, uart_rxd, rx_ready;
  logic       rx_valid, frame_error, overrun;
  logic [7:0] rx_data;

  uart_rx_stream #(
    .CYCLES_PER_BIT(CPB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .m_areset   (m_areset),
    .uart_rxd   (uart_rxd),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  int         cyc = 0, last_t0 = 0, first_vcyc = -1;
  int         vcount = 0, pcount = 0, fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
  int         rdy_at = -1;
  bit         rnd_ready = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (vcount == 0) first_vcyc = cyc;
      vcount++;
    end
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid && rx_ready) begin
      pcount++;
      if (exp_q.size() == 0) chk("pop_unexpected", rx_valid, 0);
      else chk("rx_data", rx_data, exp_q.pop_front());
    end
  end

  task automatic clear();
    fe_cnt = 0; ov_cnt = 0; exp_fe = 0; exp_ov = 0;
    vcount = 0; pcount = 0; first_vcyc = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  // Reference model at the stop-bit decision: good frames enter the buffer unless it is full.
  task automatic model_stop(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    if (stop_ok && par_ok) begin
      if (exp_q.size() >= DEPTH) exp_ov++;
      else exp_q.push_back(b);
    end else begin
      exp_fe++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    logic [NBITS-1:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^b) ^ !par_ok;
`endif
    bits[NBITS-1] = stop_ok;
    @(posedge clk); #1;
    last_t0 = cyc;
    for (int c = 0; c < NBITS * CPB; c++) begin
      uart_rxd = bits[c / CPB];
      if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
      if (c == rdy_at) rx_ready = 1'b1;
      if (c == STOP_AT) model_stop(b, stop_ok, par_ok);
      @(posedge clk); #1;
    end
    uart_rxd = 1'b1;
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || rx_valid) && n < limit) begin
      idle(1);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    m_areset = 1'b1; uart_rxd = 1'b1; rx_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_ovr", overrun, 0);
    m_areset = 1'b0;
    idle(5);

    // Single byte with the consumer always ready.
    clear(); rx_ready = 1'b1;
    send_frame(8'hAB, 1, 1);
    idle(20);
    chk("t1_latency", first_vcyc - last_t0, STOP_AT);
    chk("t1_vcycles", vcount, 1);
    chk("t1_pops", pcount, 1);
    chk("t1_ferr", fe_cnt, 0);
    chk("t1_ovr", ov_cnt, 0);

    // Short low glitch must not start a frame.
    clear();
    uart_rxd = 1'b0; idle(4);
    uart_rxd = 1'b1; idle(40);
    chk("t2_vcycles", vcount, 0);
    chk("t2_ferr", fe_cnt, 0);

    // Stop bit held low (break), then a clean byte.
    clear();
    send_frame(8'h55, 0, 1);
    uart_rxd = 1'b0; idle(20);
    uart_rxd = 1'b1; idle(8);
    chk("t3_ferr_break", fe_cnt, 1);
    chk("t3_no_valid", vcount, 0);
    send_frame(8'h3C, 1, 1);
    idle(20);
    chk("t3_ferr", fe_cnt, exp_fe);
    chk("t3_pops", pcount, 1);

    // Overrun on the fifth byte with the consumer stalled.
    clear(); rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 1);
    idle(8);
    chk("t4_ovr", ov_cnt, 1);
    chk("t4_ovr_model", ov_cnt, exp_ov);
    chk("t4_valid", rx_valid, 1);
    chk("t4_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    drain("t4_drain", 40);
    idle(2);
    chk("t4_pops", pcount, 4);
    chk("t4_empty", rx_valid, 0);

    // Full buffer, but the head leaves in the same cycle as the fifth push.
    clear(); rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1, 1);
    rdy_at = STOP_AT - 1;
    send_frame(8'h14, 1, 1);
    rdy_at = -1;
    drain("t5_drain", 40);
    idle(4);
    chk("t5_ovr", ov_cnt, 0);
    chk("t5_pops", pcount, 5);

    // Reset in the middle of 0xF0 while one byte is buffered.
    clear(); rx_ready = 1'b0;
    send_frame(8'h77, 1, 1);
    idle(4);
    chk("t6_prefill", rx_valid, 1);
    uart_rxd = 1'b0;
    idle(4 * CPB);                     // start bit plus the three low LSBs of 0xF0
    m_areset = 1'b1; #1;
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_data", rx_data, 0);
    exp_q.delete();
    idle(3);
    m_areset = 1'b0; uart_rxd = 1'b1;
    idle(5);
    rx_ready = 1'b1;
    send_frame(8'h0F, 1, 1);
    idle(20);
    chk("t6_pops", pcount, 1);
    chk("t6_ferr", fe_cnt, 0);
    chk("t6_ovr", ov_cnt, 0);

`ifdef UART_RX_PARITY_EN
    clear(); rx_ready = 1'b1;
    send_frame(8'hA5, 1, 0);
    idle(20);
    chk("t7_par_ferr", fe_cnt, 1);
    chk("t7_par_drop", vcount, 0);
`endif

    // Randomized traffic with a randomly stalling consumer.
    clear(); rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      logic [7:0] b;
      bit stop_ok, par_ok;
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
      par_ok  = (PAR == 0) || ($urandom_range(0, 7) != 0);
      send_frame(b, stop_ok, par_ok);
      idle(stop_ok ? $urandom_range(0, 6) : 4 + $urandom_range(0, 6));
    end
    drain("rnd_drain", 400);
    rnd_ready = 1'b0;
    idle(4);
    chk("rnd_ferr", fe_cnt, exp_fe);
    chk("rnd_ovr", ov_cnt, exp_ov);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
